// File: rtl/clk_phase_gen.sv
// Multi-channel clock-phase generator: one programmable phase counter drives NUM_CH
// windowed clock outputs. Optional config range check enabled by CLK_PHASE_GEN_CFGCHK_EN.
module clk_phase_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned PHASE_W = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        cfg_load,
    input  logic [PHASE_W-1:0]          period_cfg,
    input  logic [NUM_CH*PHASE_W-1:0]   rise_cfg,
    input  logic [NUM_CH*PHASE_W-1:0]   fall_cfg,
    output logic [NUM_CH-1:0]           ch_clk,
    output logic [PHASE_W-1:0]          phase,
    output logic                        wrap,
    output logic                        cfg_pend,
    output logic                        cfg_err
);

    localparam logic [PHASE_W-1:0] PH_ONE     = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PERIOD_RST = '1;
    localparam logic [PHASE_W-1:0] FALL_RST   = PH_ONE << (PHASE_W - 1);

    logic [PHASE_W-1:0]              cnt;
    logic [PHASE_W-1:0]              act_period;
    logic [PHASE_W-1:0]              pend_period;
    logic [NUM_CH-1:0][PHASE_W-1:0]  act_rise;
    logic [NUM_CH-1:0][PHASE_W-1:0]  act_fall;
    logic [NUM_CH-1:0][PHASE_W-1:0]  pend_rise;
    logic [NUM_CH-1:0][PHASE_W-1:0]  pend_fall;

    logic [PHASE_W-1:0]              eff_period;
    logic                            at_wrap;
    logic                            apply;
    logic [NUM_CH-1:0]               win;
    logic [PHASE_W-1:0]              nxt_period;
    logic [NUM_CH-1:0][PHASE_W-1:0]  nxt_rise;
    logic [NUM_CH-1:0][PHASE_W-1:0]  nxt_fall;

    assign eff_period = (act_period == '0) ? PH_ONE : act_period;
    assign at_wrap    = (cnt >= eff_period);
    assign apply      = !run || at_wrap;

    assign phase = cnt;
    // Gated by reset so wrap reads 0 while reset is held.
    assign wrap  = reset && run && (cnt == '0);

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (act_rise[i] < act_fall[i])
                win[i] = (cnt >= act_rise[i]) && (cnt < act_fall[i]);
            else if (act_rise[i] > act_fall[i])
                win[i] = (cnt >= act_rise[i]) || (cnt < act_fall[i]);
        end
    end

    // A load coinciding with an apply point bypasses the pending stage.
    always_comb begin
        if (cfg_load) begin
            nxt_period = period_cfg;
            nxt_rise   = rise_cfg;
            nxt_fall   = fall_cfg;
        end else begin
            nxt_period = pend_period;
            nxt_rise   = pend_rise;
            nxt_fall   = pend_fall;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt         <= '0;
            ch_clk      <= '0;
            cfg_pend    <= 1'b0;
            act_period  <= PERIOD_RST;
            pend_period <= PERIOD_RST;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                act_rise[i]  <= '0;
                act_fall[i]  <= FALL_RST;
                pend_rise[i] <= '0;
                pend_fall[i] <= FALL_RST;
            end
        end else begin
            cnt    <= apply ? '0 : cnt + 1'b1;
            ch_clk <= run ? win : '0;
            // Pending mirrors active after every apply so a later apply never reverts.
            if (apply) begin
                act_period  <= nxt_period;
                act_rise    <= nxt_rise;
                act_fall    <= nxt_fall;
                pend_period <= nxt_period;
                pend_rise   <= nxt_rise;
                pend_fall   <= nxt_fall;
                cfg_pend    <= 1'b0;
            end else if (cfg_load) begin
                pend_period <= period_cfg;
                pend_rise   <= rise_cfg;
                pend_fall   <= fall_cfg;
                cfg_pend    <= 1'b1;
            end
        end
    end

`ifdef CLK_PHASE_GEN_CFGCHK_EN
    logic [PHASE_W-1:0] nxt_eff;
    logic               nxt_err;

    always_comb begin
        nxt_eff = (nxt_period == '0) ? PH_ONE : nxt_period;
        nxt_err = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((nxt_rise[i] > nxt_eff) || (nxt_fall[i] > nxt_eff))
                nxt_err = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            cfg_err <= 1'b0;
        else if (apply)
            cfg_err <= nxt_err;
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_phase_gen.sv
// Self-checking bench for clk_phase_gen (NUM_CH=4, PHASE_W=3): cycle model plus directed checks.
module tb_clk_phase_gen;

    localparam int NCH = 4;
    localparam int W   = 3;
    localparam int M   = 8;

    logic              clock;
    logic              reset;
    logic              run;
    logic              cfg_load;
    logic [W-1:0]      period_cfg;
    logic [NCH*W-1:0]  rise_cfg;
    logic [NCH*W-1:0]  fall_cfg;
    logic [NCH-1:0]    ch_clk;
    logic [W-1:0]      phase;
    logic              wrap;
    logic              cfg_pend;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;

    clk_phase_gen #(.NUM_CH(NCH), .PHASE_W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .cfg_load   (cfg_load),
        .period_cfg (period_cfg),
        .rise_cfg   (rise_cfg),
        .fall_cfg   (fall_cfg),
        .ch_clk     (ch_clk),
        .phase      (phase),
        .wrap       (wrap),
        .cfg_pend   (cfg_pend),
        .cfg_err    (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit m_valid = 0;
    int m_cnt, m_ch, m_pend, m_err;
    int a_per, p_per;
    int a_rise[NCH], a_fall[NCH], p_rise[NCH], p_fall[NCH];

    // High when c lies in the circular interval [rise, fall) of the phase ring.
    function automatic int in_window(input int c, input int r, input int f);
        int off, len;
        off = ((c - r) % M + M) % M;
        len = ((f - r) % M + M) % M;
        return (off < len) ? 1 : 0;
    endfunction

    function automatic int field(input logic [NCH*W-1:0] v, input int i);
        return int'((v >> (i * W)) & 7);
    endfunction

    always @(posedge clock) begin : model
        int p, np, nch, ep;
        bit boundary;
        if (!reset) begin
            m_cnt = 0; m_ch = 0; m_pend = 0; m_err = 0;
            a_per = M - 1; p_per = M - 1;
            for (int i = 0; i < NCH; i++) begin
                a_rise[i] = 0; a_fall[i] = M / 2;
                p_rise[i] = 0; p_fall[i] = M / 2;
            end
            m_valid = 1;
        end else begin
            p = (a_per < 1) ? 1 : a_per;
            nch = 0;
            if (run)
                for (int i = 0; i < NCH; i++)
                    nch |= in_window(m_cnt, a_rise[i], a_fall[i]) << i;
            boundary = !run || (m_cnt == p);
            np = boundary ? 0 : m_cnt + 1;
            if (boundary) begin
                if (cfg_load) begin
                    p_per = int'(period_cfg);
                    for (int i = 0; i < NCH; i++) begin
                        p_rise[i] = field(rise_cfg, i);
                        p_fall[i] = field(fall_cfg, i);
                    end
                end
                a_per = p_per;
                for (int i = 0; i < NCH; i++) begin
                    a_rise[i] = p_rise[i];
                    a_fall[i] = p_fall[i];
                end
                m_pend = 0;
`ifdef CLK_PHASE_GEN_CFGCHK_EN
                ep = (a_per < 1) ? 1 : a_per;
                m_err = 0;
                for (int i = 0; i < NCH; i++)
                    if (a_rise[i] > ep || a_fall[i] > ep) m_err = 1;
`else
                ep = 0;
                m_err = 0;
`endif
            end else if (cfg_load) begin
                p_per = int'(period_cfg);
                for (int i = 0; i < NCH; i++) begin
                    p_rise[i] = field(rise_cfg, i);
                    p_fall[i] = field(fall_cfg, i);
                end
                m_pend = 1;
            end
            m_cnt = np;
            m_ch  = nch;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("ch_clk",   int'(ch_clk),   m_ch);
            check("phase",    int'(phase),    m_cnt);
            check("wrap",     int'(wrap),     (reset && run && m_cnt == 0) ? 1 : 0);
            check("cfg_pend", int'(cfg_pend), m_pend);
            check("cfg_err",  int'(cfg_err),  m_err);
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (int'(phase) != p && n < 40) begin
            cyc();
            n++;
        end
        check("wait_phase", int'(phase), p);
    endtask

    task automatic load(input int per, input logic [NCH*W-1:0] r, input logic [NCH*W-1:0] f);
        period_cfg = W'(per);
        rise_cfg   = r;
        fall_cfg   = f;
        cfg_load   = 1'b1;
        cyc();
        cfg_load   = 1'b0;
    endtask

    function automatic logic [NCH*W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    int hi;
    int seq4[4];
    int seq6[6];

    initial begin
        reset = 1'b0; run = 1'b1; cfg_load = 1'b0;
        period_cfg = '0; rise_cfg = '0; fall_cfg = '0;

        // Reset state
        cyc();
        check("rst_ch_clk", int'(ch_clk), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_pend", int'(cfg_pend), 0);
        check("rst_wrap", int'(wrap), 0);
        cyc();
        reset = 1'b1;

        // Default: every channel 4 high / 4 low over period 8
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            hi += $countones(ch_clk);
        end
        check("t1_duty", hi, 16);

        // ch0 0/4, ch1 5/1, period 8
        load(7, pack(0, 5, 0, 0), pack(4, 1, 4, 4));
        wait_phase(0);
        wait_phase(1);
        check("t2_ph1", int'(ch_clk[1:0]), 3);
        wait_phase(4);
        check("t2_ph4", int'(ch_clk[1:0]), 1);
        wait_phase(6);
        check("t2_ph6", int'(ch_clk[1:0]), 2);
        wait_phase(0);
        check("t2_ph0", int'(ch_clk[1:0]), 2);

        // Load period 4 mid-period; held pending until wrap
        wait_phase(2);
        load(3, pack(0, 5, 0, 0), pack(4, 1, 4, 4));
        check("t3_phase3", int'(phase), 3);
        check("t3_pend3", int'(cfg_pend), 1);
        wait_phase(7);
        check("t3_pend7", int'(cfg_pend), 1);
        cyc();
        check("t3_phase0", int'(phase), 0);
        check("t3_pend0", int'(cfg_pend), 0);
        seq4 = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t3_seq", int'(phase), seq4[k]);
        end

        // Back to period 8, then write-through load at phase 7
        load(7, pack(0, 5, 0, 0), pack(4, 1, 4, 4));
        wait_phase(0);
        wait_phase(7);
        load(5, pack(0, 5, 0, 0), pack(4, 1, 4, 4));
        check("t4_phase0", int'(phase), 0);
        check("t4_pend", int'(cfg_pend), 0);
        seq6 = '{1, 2, 3, 4, 5, 0};
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t4_seq", int'(phase), seq6[k]);
            check("t4_pend_seq", int'(cfg_pend), 0);
        end

        // Two loads before apply: last write wins (period 6, ch2 3/3)
        cyc();
        load(2, pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        load(5, pack(0, 5, 3, 0), pack(4, 1, 3, 4));
        wait_phase(0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t5_seq", int'(phase), seq6[k]);
            check("t5_ch2_low", int'(ch_clk[2]), 0);
        end
        wait_phase(5);
        run = 1'b0;
        cyc();
        check("t5_stop_phase", int'(phase), 0);
        check("t5_stop_ch", int'(ch_clk), 0);
        check("t5_stop_wrap", int'(wrap), 0);
        cyc();
        check("t5_hold_phase", int'(phase), 0);
        run = 1'b1;
        #1;
        check("t5_restart_phase", int'(phase), 0);
        check("t5_restart_wrap", int'(wrap), 1);
        cyc();
        check("t5_restart_ph1", int'(phase), 1);

        // Out-of-range fall on ch3 with period 4
        load(3, pack(0, 0, 0, 0), pack(4, 1, 4, 6));
        wait_phase(0);
`ifdef CLK_PHASE_GEN_CFGCHK_EN
        check("t6_err_set", int'(cfg_err), 1);
`else
        check("t6_err_off", int'(cfg_err), 0);
`endif
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t6_ch3_high", int'(ch_clk[3]), 1);
        end
        load(3, pack(0, 0, 0, 0), pack(4, 1, 4, 2));
        wait_phase(0);
        check("t6_err_clr", int'(cfg_err), 0);

        // Reset mid-period overrides cfg_load and restores defaults
        wait_phase(2);
        reset = 1'b0;
        period_cfg = W'(1);
        cfg_load = 1'b1;
        cyc();
        check("t7_phase", int'(phase), 0);
        check("t7_pend", int'(cfg_pend), 0);
        check("t7_ch", int'(ch_clk), 0);
        cfg_load = 1'b0;
        reset = 1'b1;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            hi += $countones(ch_clk);
        end
        check("t7_duty", hi, 16);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
